// File: rtl/query_pourer.sv
// query_pourer
// -----------------------------------------------------------------------------
// Upstream feeder of the query-base buffer. Unpacks 2-bit query bases from
// packed memory words (base k at bits [2k+1:2k], LSB first) and pours them one
// per cycle as {valid, base[1:0]}, framing each sequence with pouring_o and a
// one-cycle pouring_last_o pulse. Emission throttles on the buffer's
// registered full flag.
//
// Optional feature (compile-time macro QP_PREFETCH_EN):
//   adds a second word register so the next word can be fetched while the
//   current one is still being poured, removing the bubble at word boundaries.
//
// Parameters:
//   WORD_BASES  bases per input word (word width = 2*WORD_BASES)
//   LEN_BIT     width of the sequence-length field
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   start_i         start one sequence (sampled only in IDLE)
//   length_i        base count captured with start_i (0 legal)
//   word_valid_i    packed word available
//   word_i          packed bases
//   word_ready_o    word accepted when word_valid_i & word_ready_o
//   full_i          downstream buffer full flag (registered in the buffer)
//   q_o             {valid, base}; 3'b000 when not emitting
//   pouring_o       sequence frame active
//   pouring_last_o  one-cycle end-of-sequence pulse
//   busy_o          state != IDLE
//   done_o          one-cycle pulse, coincident with pouring_last_o
// -----------------------------------------------------------------------------
module query_pourer #(
  parameter int WORD_BASES = 16,
  parameter int LEN_BIT    = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [LEN_BIT-1:0]      length_i,
  input  logic                    word_valid_i,
  input  logic [2*WORD_BASES-1:0] word_i,
  output logic                    word_ready_o,
  input  logic                    full_i,
  output logic [2:0]              q_o,
  output logic                    pouring_o,
  output logic                    pouring_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int WW = 2 * WORD_BASES;
  localparam int IW = (WORD_BASES > 1) ? $clog2(WORD_BASES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_POUR,
    S_LAST
  } state_e;

  state_e state_q, state_d;

  logic [LEN_BIT-1:0] remain_q, remain_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WW-1:0]      word_q, word_d;
  logic [2:0]         q_q, q_d;
  logic               pouring_q, pouring_d;
  logic               last_q, last_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

`ifdef QP_PREFETCH_EN
  localparam int CW = LEN_BIT + 1;
  logic [WW-1:0] pf_word_q, pf_word_d;
  logic          pf_valid_q, pf_valid_d;
`endif

  logic hs;
  logic emit;
  logic wrap;
  logic last_base;

  // word_ready_o is registered, so the handshake is qualified by the
  // registered ready that the source saw this cycle.
  assign hs        = word_valid_i & ready_q;
  assign emit      = (state_q == S_POUR) & ~full_i;
  assign wrap      = (idx_q == IW'(WORD_BASES - 1));
  assign last_base = (remain_q == LEN_BIT'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (length_i == '0) ? S_LAST : S_FETCH;
        end
      end
      S_FETCH: begin
        if (hs) begin
          state_d = S_POUR;
        end
      end
      S_POUR: begin
        if (emit) begin
          if (last_base) begin
            state_d = S_LAST;
          end else if (wrap) begin
`ifdef QP_PREFETCH_EN
            // A word already held, or arriving right now, lets the stream
            // continue without the FETCH bubble.
            state_d = (pf_valid_q || hs) ? S_POUR : S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_LAST: begin
        if (!full_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    remain_d  = remain_q;
    idx_d     = idx_q;
    word_d    = word_q;
    q_d       = '0;
    pouring_d = pouring_q;
    last_d    = 1'b0;
`ifdef QP_PREFETCH_EN
    pf_word_d  = pf_word_q;
    pf_valid_d = pf_valid_q;
`endif

    case (state_q)
      S_IDLE: begin
        pouring_d = 1'b0;
        if (start_i) begin
          remain_d = length_i;
          idx_d    = '0;
        end
      end
      S_FETCH: begin
        // pouring_o holds: 0 before the first word, 1 at later boundaries.
        if (hs) begin
          word_d = word_i;
          idx_d  = '0;
        end
      end
      S_POUR: begin
        if (emit) begin
          q_d       = {1'b1, word_q[{idx_q, 1'b0} +: 2]};
          pouring_d = 1'b1;
          remain_d  = remain_q - LEN_BIT'(1);
          idx_d     = wrap ? '0 : idx_q + IW'(1);
        end
`ifdef QP_PREFETCH_EN
        if (emit && wrap && !last_base) begin
          if (pf_valid_q) begin
            word_d     = pf_word_q;
            pf_valid_d = 1'b0;
          end else if (hs) begin
            word_d = word_i;
          end
        end else if (hs) begin
          pf_word_d  = word_i;
          pf_valid_d = 1'b1;
        end
`endif
      end
      S_LAST: begin
`ifdef QP_PREFETCH_EN
        pf_valid_d = 1'b0;
`endif
        if (!full_i) begin
          pouring_d = 1'b0;
          last_d    = 1'b1;
        end
      end
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_FETCH);
`ifdef QP_PREFETCH_EN
    // Only prefetch when the sequence needs bases beyond the current word.
    if ((state_d == S_POUR) && !pf_valid_d &&
        ({1'b0, remain_d} > (CW'(WORD_BASES) - CW'(idx_d)))) begin
      ready_d = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain_q  <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      q_q       <= '0;
      pouring_q <= 1'b0;
      last_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef QP_PREFETCH_EN
      pf_word_q  <= '0;
      pf_valid_q <= 1'b0;
`endif
    end else begin
      remain_q  <= remain_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      q_q       <= q_d;
      pouring_q <= pouring_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef QP_PREFETCH_EN
      pf_word_q  <= pf_word_d;
      pf_valid_q <= pf_valid_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    q_o            = q_q;
    pouring_o      = pouring_q;
    pouring_last_o = last_q;
    done_o         = last_q;
    busy_o         = busy_q;
    word_ready_o   = ready_q;
  end

endmodule

// File: tb/tb_query_pourer.sv
// tb_query_pourer
// Self-checking bench for query_pourer. A reference model derives the expected
// base stream from the packed words (base k = word[k/16] bits [2(k%16)+1:2(k%16)])
// truncated to the sequence length, and checks framing rules cycle by cycle.
module tb_query_pourer;

  localparam int WB = 16;
  localparam int LB = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [LB-1:0] length_i;
  logic          word_valid_i;
  logic [2*WB-1:0] word_i;
  logic          word_ready_o;
  logic          full_i;
  logic [2:0]    q_o;
  logic          pouring_o;
  logic          pouring_last_o;
  logic          busy_o;
  logic          done_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] words[$];
  logic [2:0]  obs[$];

  always #5 clk = ~clk;

  query_pourer #(.WORD_BASES(WB), .LEN_BIT(LB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .length_i       (length_i),
    .word_valid_i   (word_valid_i),
    .word_i         (word_i),
    .word_ready_o   (word_ready_o),
    .full_i         (full_i),
    .q_o            (q_o),
    .pouring_o      (pouring_o),
    .pouring_last_o (pouring_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  function automatic logic [1:0] model_base(input int k);
    logic [31:0] w;
    w = words[k / WB];
    return w[2*(k % WB) +: 2];
  endfunction

  // Runs one sequence against the model. Outputs: gaps = idle cycles between
  // first and last valid base, hs_cnt = word handshakes, end_cyc = cycle index
  // (after the start edge) where pouring_last_o was seen.
  task automatic run_seq(input int len, input int full_pct, input int valid_pct,
                         input bit noise, input int stall_at, input int full_hold,
                         output int gaps, output int hs_cnt, output int end_cyc);
    int pos, widx, nwords, first_cyc, last_cyc, stall_left;
    bit seen_first, ended, prev_full, stall_done, exp_pour;
    pos = 0; widx = 0; hs_cnt = 0; first_cyc = 0; last_cyc = 0; end_cyc = -1;
    seen_first = 0; ended = 0; stall_left = 0; stall_done = 0;
    nwords = (len + WB - 1) / WB;
    obs.delete();
    @(negedge clk);
    start_i = 1'b1; length_i = 12'(len); word_valid_i = 1'b0;
    full_i = (full_hold > 0); prev_full = full_i;
    for (int cyc = 0; cyc < 20000 && !ended; cyc++) begin
      @(negedge clk);
      if (q_o[2]) begin
        checks++;
        if (pos >= len) begin
          errors++; $display("FAIL extra_base: got q=%0d after %0d bases, required none", q_o, pos);
        end else if (q_o[1:0] !== model_base(pos)) begin
          errors++; $display("FAIL base_order: base %0d got %0d, required %0d", pos, q_o[1:0], model_base(pos));
        end
        checks++;
        if (prev_full) begin
          errors++; $display("FAIL emit_under_full: base %0d emitted while full_i=1 was sampled, required no emit", pos);
        end
        obs.push_back(q_o);
        if (!seen_first) first_cyc = cyc;
        seen_first = 1; last_cyc = cyc; pos++;
      end else begin
        checks++;
        if (q_o !== 3'b000) begin
          errors++; $display("FAIL q_idle: got %b, required 000", q_o);
        end
      end
      exp_pour = seen_first && !pouring_last_o;
      checks++;
      if (pouring_o !== exp_pour) begin
        errors++; $display("FAIL framing: cycle %0d pouring_o=%b, required %b", cyc, pouring_o, exp_pour);
      end
      if (pouring_last_o === 1'b1) begin
        checks++;
        if (done_o !== 1'b1 || pos != len || prev_full) begin
          errors++; $display("FAIL last_pulse: done=%b bases=%0d prev_full=%b, required done=1 bases=%0d prev_full=0",
                             done_o, pos, prev_full, len);
        end
        ended = 1; end_cyc = cyc;
      end else begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++; $display("FAIL done_stray: done_o=%b without pouring_last_o, required 0", done_o);
        end
        start_i  = noise && (busy_o === 1'b1) && ($urandom_range(0, 3) == 0);
        length_i = 12'($urandom_range(0, 4095));
        if (cyc < full_hold) begin
          full_i = 1'b1;
        end else if (stall_at >= 0) begin
          if (!stall_done && pos == stall_at) begin stall_left = 3; stall_done = 1; end
          full_i = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end else begin
          full_i = ($urandom_range(0, 99) < full_pct);
        end
        prev_full = full_i;
        word_valid_i = (widx < nwords) && ($urandom_range(0, 99) < valid_pct);
        word_i = word_valid_i ? words[widx] : $urandom;
        if (word_valid_i && word_ready_o === 1'b1) begin widx++; hs_cnt++; end
      end
    end
    start_i = 1'b0; word_valid_i = 1'b0; full_i = 1'b0;
    checks++;
    if (!ended) begin
      errors++; $display("FAIL timeout: no pouring_last_o after 20000 cycles, bases=%0d of %0d", pos, len);
    end
    checks++;
    if (pos != len) begin
      errors++; $display("FAIL base_count: got %0d bases, required %0d", pos, len);
    end
    checks++;
    if (hs_cnt != nwords) begin
      errors++; $display("FAIL handshakes: got %0d, required %0d", hs_cnt, nwords);
    end
    gaps = seen_first ? (last_cyc - first_cyc + 1 - len) : 0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || pouring_last_o !== 1'b0 || word_ready_o !== 1'b0 || pouring_o !== 1'b0) begin
      errors++; $display("FAIL post_idle: busy=%b last=%b ready=%b pour=%b, required all 0",
                         busy_o, pouring_last_o, word_ready_o, pouring_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; length_i = '0; word_valid_i = 1'b0; word_i = '0; full_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({q_o, pouring_o, pouring_last_o, word_ready_o, busy_o, done_o} !== 8'b0) begin
      errors++; $display("FAIL reset_state: q=%b pour=%b last=%b ready=%b busy=%b done=%b, required all 0",
                         q_o, pouring_o, pouring_last_o, word_ready_o, busy_o, done_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int gaps, hs, endc;
    logic [2:0] exp_q [5];
    // 0x3E4: bases 0..4 are 0,1,2,3,3 (bits[9:8] = 2'b11)
    exp_q = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    words.delete(); words.push_back(32'h0000_03E4);
    run_seq(5, 0, 100, 0, -1, 0, gaps, hs, endc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_q%0d: got %b, required %b", i, (i < obs.size()) ? obs[i] : 3'bxxx, exp_q[i]);
      end
    end
    checks++;
    if (gaps != 0 || hs != 1 || endc != 7) begin
      errors++; $display("FAIL basic_timing: gaps=%0d hs=%0d end=%0d, required 0 1 7", gaps, hs, endc);
    end
  endtask

  task automatic test_word_boundary();
    int gaps, hs, endc, exp_gaps;
`ifdef QP_PREFETCH_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    fill_words(2);
    run_seq(18, 0, 100, 0, -1, 0, gaps, hs, endc);
    checks++;
    if (gaps != exp_gaps || hs != 2) begin
      errors++; $display("FAIL word_boundary: gaps=%0d hs=%0d, required %0d 2", gaps, hs, exp_gaps);
    end
  endtask

  task automatic test_backpressure();
    int gaps, hs, endc;
    fill_words(1);
    run_seq(10, 0, 100, 0, 4, 0, gaps, hs, endc);
    checks++;
    if (gaps != 3) begin
      errors++; $display("FAIL backpressure_gaps: got %0d stall cycles, required 3", gaps);
    end
  endtask

  task automatic test_empty();
    int gaps, hs, endc;
    words.delete();
    run_seq(0, 0, 100, 0, -1, 4, gaps, hs, endc);
    checks++;
    if (endc != 5 || hs != 0) begin
      errors++; $display("FAIL empty_seq: end=%0d hs=%0d, required 5 0", endc, hs);
    end
  endtask

  task automatic test_start_ignored();
    int gaps, hs, endc;
    fill_words(3);
    run_seq(40, 20, 70, 1, -1, 0, gaps, hs, endc);
  endtask

  task automatic test_random();
    int gaps, hs, endc, len;
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 100);
      fill_words((len + WB - 1) / WB);
      run_seq(len, 30, 60, 0, -1, $urandom_range(0, 3), gaps, hs, endc);
    end
  endtask

  task automatic test_reset_mid();
    int pos, widx, gaps, hs, endc;
    bit ok;
    pos = 0; widx = 0;
    fill_words(2);
    @(negedge clk);
    start_i = 1'b1; length_i = 12'd20; full_i = 1'b0; word_valid_i = 1'b0;
    for (int cyc = 0; cyc < 200 && pos < 5; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (q_o[2]) pos++;
      word_valid_i = (widx < 2);
      word_i = words[widx < 2 ? widx : 1];
      if (word_valid_i && word_ready_o === 1'b1) widx++;
    end
    checks++;
    if (pos != 5) begin
      errors++; $display("FAIL reset_mid_setup: got %0d bases before reset, required 5", pos);
    end
    rst_n = 1'b0; word_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (q_o !== 3'b000 || pouring_o !== 1'b0 || busy_o !== 1'b0 || pouring_last_o !== 1'b0 || word_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: q=%b pour=%b busy=%b last=%b ready=%b, required all 0",
                         q_o, pouring_o, busy_o, pouring_last_o, word_ready_o);
    end
    rst_n = 1'b1;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (pouring_last_o !== 1'b0 || busy_o !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reset_mid_no_last: stray pouring_last_o/busy after reset, required none");
    end
    fill_words(1);
    run_seq(7, 10, 80, 0, -1, 0, gaps, hs, endc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_word_boundary();
    test_backpressure();
    test_empty();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
